des_keysched_ctrl: RTL and testbench
====================================

DES_KEYSCHED_CTRL -- requirements
Module: des_keysched_ctrl

Interface
REQ-001 SHALL have parameter: ROUNDS, default 16, number of round keys issued per key load (legal 1..16; values below 16 are for reduced-round test builds only).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start_i  input  1  load key_i and begin a schedule; sampled only in IDLE.
REQ-005 SHALL have port: key_i  input  64  DES key incl. parity bits, bit 63 = DES bit 1.
REQ-006 SHALL have port: decrypt_i  input  1  sampled with start_i; 1 = issue keys in reverse order.
REQ-007 SHALL have port: abort_i  input  1  synchronous flush to IDLE.
REQ-008 SHALL have port: rk_o  output  48  current round key (PC-2 output).
REQ-009 SHALL have port: rk_valid_o  output  1  rk_o/round_o valid.
REQ-010 SHALL have port: rk_ready_i  input  1  consumer accepts the key when rk_valid_o&&rk_ready_i.
REQ-011 SHALL have port: round_o  output  4  DES round index (0..15) of rk_o.
REQ-012 SHALL have port: busy_o  output  1  high in every state except IDLE.
REQ-013 SHALL have port: done_o  output  1  one-cycle pulse after the last key is accepted.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, DONE; IDLE->ISSUE on start_i, ISSUE->DONE on the handshake of the last key, DONE->IDLE unconditionally after one cycle.
REQ-015 SHALL, on start_i in IDLE, apply PC-1 to key_i to form 28-bit halves C0/D0 and present the first key with rk_valid_o=1 in the next cycle (latency 1).
REQ-016 SHALL use 28-bit circular rotation (never a plain shift); rotate amount is 1 for rounds 0,1,8,15 and 2 otherwise.
REQ-017 SHALL, in encrypt order, issue round r = 0..ROUNDS-1 as PC-2(C(r+1),D(r+1)), rotating left before each key.
REQ-018 SHALL, in decrypt order, issue round r = 15 down to 16-ROUNDS, first key PC-2(C0,D0) (== C16/D16), then rotating right by the amount of the round just issued.
REQ-019 SHALL hold rk_o, round_o and rk_valid_o stable while rk_valid_o=1 and rk_ready_i=0.
REQ-020 SHALL advance to the next key one cycle after each handshake, keeping rk_valid_o continuously high, so that back-to-back ready gives one key per cycle.
REQ-021 SHALL ignore start_i outside IDLE; start_i in DONE is not queued.
REQ-022 SHALL, on abort_i (any state), go to IDLE next cycle with rk_valid_o=0 and no done_o pulse; abort_i takes priority over a simultaneous handshake or start_i.
REQ-023 SHALL never assert rk_valid_o in IDLE or DONE.

Reset
REQ-024 SHALL, on rst_n low at any time including mid-schedule, immediately set the state to IDLE, rk_o=0, rk_valid_o=0, round_o=0, busy_o=0, done_o=0 and clear C/D.
REQ-025 SHALL leave reset in IDLE and require a fresh start_i.

Configuration
REQ-026 SHALL honour macro DES_KEYSCHED_DECRYPT_EN: when defined, REQ-018 reverse order is supported; when undefined, decrypt_i is ignored, only encrypt order exists, and no right-rotate logic is synthesised.

Structure
REQ-027 SHALL take the PC-1 and PC-2 tables, the rotate-amount schedule, the ROUNDS default and the FSM state enum from shared package des_pkg.
REQ-028 SHALL place the rotate+PC-2 step in one sub-module des_key_round (inputs C,D,round,direction; outputs next C,D and the 48-bit key), reusable by other DES blocks.

Verification
REQ-029 SHALL pass: key 133457799BBCDFF1, encrypt, ready tied 1 -> round 0 rk_o=1B02EFFC7072, round 15 rk_o=CB3D8B0E17F5, 16 consecutive valid cycles, done_o on cycle 17.
REQ-030 SHALL pass: same key, decrypt_i=1 -> first key round_o=15, rk_o=CB3D8B0E17F5; last key round_o=0, rk_o=1B02EFFC7072.
REQ-031 SHALL pass: random ready stalls -> every key is held stable while stalled, the key sequence is identical to REQ-029, and exactly 16 handshakes occur.
REQ-032 SHALL pass: abort_i at round 7 -> IDLE next cycle, no done_o, and a subsequent start_i reproduces round 0 correctly.
REQ-033 SHALL pass: rst_n low at round 9 -> all outputs 0 immediately; start_i while busy -> ignored, with the sequence unaltered.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES constants: PC-1/PC-2 tables, rotate-amount schedule, key-schedule FSM states.
package des_pkg;

  localparam int ROUNDS_DEFAULT = 16;

  // DES bit numbering: bit 1 is the MSB of the key word.
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // bit r set when round r rotates by a single position
  localparam logic [15:0] ROT_ONE = 16'h8103;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } ksState;

  function automatic logic rotTwo(input logic [3:0] rnd);
    return !ROT_ONE[rnd];
  endfunction

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] cd;
    cd = '0;
    for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1[i])];
    return cd;
  endfunction

  function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
    logic [55:0] cd;
    logic [47:0] k;
    cd = {c, d};
    k  = '0;
    for (int i = 0; i < 48; i++) k[6'(47 - i)] = cd[6'(56 - PC2[i])];
    return k;
  endfunction

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

endpackage

// File: rtl/des_key_round.sv
// One DES key-schedule step: rotate C/D for a round and form its PC-2 round key.
// Right rotation (reverse order) exists only when DES_KEYSCHED_DECRYPT_EN is defined.
module des_key_round
  import des_pkg::*;
(
  input  logic [27:0] c,
  input  logic [27:0] d,
  input  logic [3:0]  round,
  input  logic        decrypt,
  output logic [27:0] cNext,
  output logic [27:0] dNext,
  output logic [47:0] roundKey
);

  logic        two;
  logic [27:0] cLeft, dLeft;

  assign two   = rotTwo(round);
  assign cLeft = rotl28(c, two);
  assign dLeft = rotl28(d, two);

`ifdef DES_KEYSCHED_DECRYPT_EN
  logic [27:0] cRight, dRight;

  assign cRight = two ? {c[1:0], c[27:2]} : {c[0], c[27:1]};
  assign dRight = two ? {d[1:0], d[27:2]} : {d[0], d[27:1]};

  // reverse order: key from the incoming halves, then step back to the previous round
  always_comb begin
    cNext    = cLeft;
    dNext    = dLeft;
    roundKey = pc2(cLeft, dLeft);
    if (decrypt) begin
      cNext    = cRight;
      dNext    = dRight;
      roundKey = pc2(c, d);
    end
  end
`else
  logic unusedDecrypt;

  assign unusedDecrypt = decrypt;
  assign cNext         = cLeft;
  assign dNext         = dLeft;
  assign roundKey      = pc2(cLeft, dLeft);
`endif

endmodule

// File: rtl/des_keysched_ctrl.sv
// DES key-schedule controller: issues ROUNDS round keys per load over a valid/ready handshake.
// Reverse (decrypt) order is built only when DES_KEYSCHED_DECRYPT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start_i, no key presented
// ISSUE | rk_o/round_o valid, advances on each handshake
// DONE  | one-cycle done_o pulse after the last key
module des_keysched_ctrl
  import des_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [63:0] key_i,
  input  logic        decrypt_i,
  input  logic        abort_i,
  output logic [47:0] rk_o,
  output logic        rk_valid_o,
  input  logic        rk_ready_i,
  output logic [3:0]  round_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [3:0] LAST_ENC = 4'(ROUNDS - 1);

  ksState      state, stateNext;
  logic [27:0] cReg, dReg, cSel, dSel, cStep, dStep;
  logic [47:0] rkReg, keyStep;
  logic [3:0]  roundReg, roundSel, lastRound;
  logic [55:0] cd0;
  logic        dirSel, handshake, lastKey, loadKey;

  assign cd0       = pc1(key_i);
  assign handshake = (state == ISSUE) && rk_ready_i;
  assign lastKey   = (roundReg == lastRound);
  assign loadKey   = !abort_i && (((state == IDLE) && start_i) || (handshake && !lastKey));

`ifdef DES_KEYSCHED_DECRYPT_EN
  localparam logic [3:0] LAST_DEC = 4'(16 - ROUNDS);
  logic dirReg;

  assign dirSel    = (state == IDLE) ? decrypt_i : dirReg;
  assign lastRound = dirReg ? LAST_DEC : LAST_ENC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       dirReg <= 1'b0;
    else if (loadKey) dirReg <= dirSel;
  end
`else
  logic unusedDecrypt;

  assign unusedDecrypt = decrypt_i;
  assign dirSel        = 1'b0;
  assign lastRound     = LAST_ENC;
`endif

  // the first key is computed straight from PC-1 of key_i so it appears one cycle after start
  always_comb begin
    cSel     = cReg;
    dSel     = dReg;
    roundSel = dirSel ? roundReg - 4'd1 : roundReg + 4'd1;
    if (state == IDLE) begin
      cSel     = cd0[55:28];
      dSel     = cd0[27:0];
      roundSel = dirSel ? 4'd15 : 4'd0;
    end
  end

  des_key_round uRound (
    .c        (cSel),
    .d        (dSel),
    .round    (roundSel),
    .decrypt  (dirSel),
    .cNext    (cStep),
    .dNext    (dStep),
    .roundKey (keyStep)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    rk_valid_o = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) stateNext = ISSUE;
      end
      ISSUE: begin
        rk_valid_o = 1'b1;
        if (handshake && lastKey) stateNext = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (abort_i) stateNext = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cReg     <= '0;
      dReg     <= '0;
      rkReg    <= '0;
      roundReg <= '0;
    end else if (loadKey) begin
      cReg     <= cStep;
      dReg     <= dStep;
      rkReg    <= keyStep;
      roundReg <= roundSel;
    end
  end

  assign rk_o    = rkReg;
  assign round_o = roundReg;

endmodule

// File: tb/tb_des_keysched_ctrl.sv
// Scoreboard bench for des_keysched_ctrl: expected round keys queued at start, checked at output.
`timescale 1ns/1ps
module tb_des_keysched_ctrl;

  logic        clk, rst_n, start_i, decrypt_i, abort_i, rk_ready_i;
  logic [63:0] key_i;
  logic [47:0] rk_o;
  logic        rk_valid_o, busy_o, done_o;
  logic [3:0]  round_o;

  des_keysched_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .key_i      (key_i),
    .decrypt_i  (decrypt_i),
    .abort_i    (abort_i),
    .rk_o       (rk_o),
    .rk_valid_o (rk_valid_o),
    .rk_ready_i (rk_ready_i),
    .round_o    (round_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  typedef struct packed {
    logic [3:0]  rnd;
    logic [47:0] key;
  } expT;

  expT         sbQ[$];
  int          nTests = 0;
  int          nFail = 0;
  int          hsCnt = 0;
  int          doneCnt = 0;
  int          doneRef, nValid, firstValid, lastValid, doneAt;
  bit          randReady = 1'b0;
  logic [47:0] refKeys [16];

`ifdef DES_KEYSCHED_DECRYPT_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif
  localparam logic [63:0] KEY_REF = 64'h133457799BBCDFF1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rk_ready_i = randReady ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  task automatic pushSeq(input bit useRef, input logic [47:0] k, input bit rev);
    expT e;
    for (int i = 0; i < 16; i++) begin
      e.rnd = rev ? 4'(15 - i) : 4'(i);
      e.key = useRef ? refKeys[e.rnd] : k;
      sbQ.push_back(e);
    end
  endtask

  task automatic startKey(input logic [63:0] k, input bit dec, input bit useRef,
                          input logic [47:0] constKey);
    pushSeq(useRef, constKey, dec && DEC_EN);
    key_i     = k;
    decrypt_i = dec;
    start_i   = 1'b1;
    step();
    start_i   = 1'b0;
  endtask

  task automatic waitDone(input string tag, input bit startInDone);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
      else        step();
    end
    chk({tag, "_done"}, 64'(seen), 64'd1);
    chk({tag, "_sb_left"}, 64'(sbQ.size()), 64'd0);
    if (startInDone) start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic waitRound(input string tag, input logic [3:0] r);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (rk_valid_o && round_o == r) seen = 1'b1;
      else                            step();
    end
    chk({tag, "_round_seen"}, 64'(seen), 64'd1);
  endtask

  // every valid key is compared against the queue head; it is only popped on a real handshake,
  // so a key that changes while stalled mismatches the still-pending head
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_o) doneCnt++;
      if (rk_valid_o) begin
        chk("valid_state", {62'd0, busy_o, done_o}, 64'd2);
        if (sbQ.size() == 0) begin
          chk("sb_underflow", 64'(rk_valid_o), 64'd0);
        end else begin
          chk("rk", 64'(rk_o), 64'(sbQ[0].key));
          chk("round", 64'(round_o), 64'(sbQ[0].rnd));
          if (rk_ready_i && !abort_i) begin
            void'(sbQ.pop_front());
            hsCnt++;
          end
        end
      end
    end
  end

  initial begin
    refKeys = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
    rst_n = 1'b1; start_i = 1'b0; decrypt_i = 1'b0; abort_i = 1'b0;
    rk_ready_i = 1'b1; key_i = '0;
    #1 rst_n = 1'b0;
    #12;
    chk("rst_rk", 64'(rk_o), 64'd0);
    chk("rst_round", 64'(round_o), 64'd0);
    chk("rst_valid", 64'(rk_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("idle_busy", 64'(busy_o), 64'd0);

    // encrypt, ready tied high: cycle-accurate latency and done position
    hsCnt = 0; nValid = 0; firstValid = -1; lastValid = -1; doneAt = -1;
    startKey(KEY_REF, 1'b0, 1'b1, '0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rk_valid_o) begin
        nValid++;
        if (firstValid < 0) firstValid = i;
        lastValid = i;
      end
      if (done_o && doneAt < 0) doneAt = i;
      step();
    end
    chk("enc_nvalid", 64'(nValid), 64'd16);
    chk("enc_first_valid", 64'(firstValid), 64'd1);
    chk("enc_last_valid", 64'(lastValid), 64'd16);
    chk("enc_done_cycle", 64'(doneAt), 64'd17);
    chk("enc_hs", 64'(hsCnt), 64'd16);
    chk("enc_sb_left", 64'(sbQ.size()), 64'd0);

    // reverse order (encrypt order expected when the decrypt build option is off)
    hsCnt = 0;
    startKey(KEY_REF, 1'b1, 1'b1, '0);
    waitDone("dec", 1'b0);
    chk("dec_hs", 64'(hsCnt), 64'd16);

    // random ready stalls
    randReady = 1'b1; hsCnt = 0;
    startKey(KEY_REF, 1'b0, 1'b1, '0);
    waitDone("stall", 1'b0);
    chk("stall_hs", 64'(hsCnt), 64'd16);

    // parity-only keys: parity bits must be dropped by PC-1
    startKey(64'hFEFEFEFEFEFEFEFE, 1'b1, 1'b0, 48'hFFFFFFFFFFFF);
    waitDone("ones", 1'b0);
    randReady = 1'b0;
    startKey(64'h0101010101010101, 1'b0, 1'b0, 48'h0);
    waitDone("zeros", 1'b0);

    // start_i while busy and while in DONE is ignored
    startKey(KEY_REF, 1'b0, 1'b1, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      step();
    end
    key_i = 64'hFEFEFEFEFEFEFEFE; decrypt_i = 1'b1; start_i = 1'b1;
    step();
    step();
    start_i = 1'b0;
    waitDone("busy_start", 1'b1);
    @(negedge clk);
    chk("done_start_busy0", 64'(busy_o), 64'd0);
    step();
    @(negedge clk);
    chk("done_start_busy1", 64'(busy_o), 64'd0);
    chk("done_start_valid", 64'(rk_valid_o), 64'd0);
    step();

    // abort while round 7 is presented with ready high
    hsCnt = 0;
    startKey(KEY_REF, 1'b0, 1'b1, '0);
    waitRound("ab", 4'd6);
    step();
    abort_i = 1'b1;
    @(negedge clk);
    step();
    abort_i = 1'b0;
    @(negedge clk);
    chk("ab_valid", 64'(rk_valid_o), 64'd0);
    chk("ab_busy", 64'(busy_o), 64'd0);
    chk("ab_hs", 64'(hsCnt), 64'd7);
    chk("ab_sb_left", 64'(sbQ.size()), 64'd9);
    sbQ.delete();
    doneRef = doneCnt;
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
    end
    chk("ab_no_done", 64'(doneCnt), 64'(doneRef));
    step();
    startKey(KEY_REF, 1'b0, 1'b1, '0);
    waitDone("ab_restart", 1'b0);

    // asynchronous reset while round 9 is presented
    startKey(KEY_REF, 1'b0, 1'b1, '0);
    waitRound("rs", 4'd8);
    step();
    chk("rs_round9", 64'(round_o), 64'd9);
    rst_n = 1'b0;
    #1;
    chk("rs_rk", 64'(rk_o), 64'd0);
    chk("rs_round", 64'(round_o), 64'd0);
    chk("rs_valid", 64'(rk_valid_o), 64'd0);
    chk("rs_busy", 64'(busy_o), 64'd0);
    chk("rs_done", 64'(done_o), 64'd0);
    chk("rs_sb_left", 64'(sbQ.size()), 64'd7);
    sbQ.delete();
    @(negedge clk) rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("rs_idle_busy", 64'(busy_o), 64'd0);
    chk("rs_idle_valid", 64'(rk_valid_o), 64'd0);
    step();
    startKey(KEY_REF, 1'b0, 1'b1, '0);
    waitDone("rs_restart", 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
